// File: rtl/wifi_cmd_sequencer_pkg.sv
// Shared definitions for the WiFi command sequencer: FSM state encodings,
// byte/entry widths and the default handshake timeout.
package wifi_cmd_sequencer_pkg;

  localparam int BYTE_W          = 8;
  localparam int ENTRY_W         = 2 * BYTE_W;
  localparam int DEF_TIMEOUT_CYC = 50000;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_START     = 2'd2,
    S_WAIT_DONE = 2'd3
  } seq_state_e;

  // Queue entries are stored as {comando, dato}.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [BYTE_W-1:0] cmd,
                                                    input logic [BYTE_W-1:0] dat);
    return {cmd, dat};
  endfunction

endpackage

// File: rtl/wifi_cmd_sequencer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO holding {comando, dato} entries; the head entry is
// valid on dout whenever empty is low. Push while full is dropped, flush wins over push/pop.
module cmd_fifo
  import wifi_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH      = ENTRY_W,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      dout
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ZERO  = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  wr_en_s;
  logic                  rd_en_s;

  assign full    = (count_r == DEPTH_C);
  assign empty   = (count_r == CNT_ZERO);
  assign count   = count_r;
  assign dout    = mem_r[rd_ptr_r];
  assign wr_en_s = push & ~full & ~flush;
  assign rd_en_s = pop & ~empty & ~flush;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents beyond the occupied window are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/wifi_cmd_sequencer.sv
// wifi_cmd_sequencer: queues {comando, dato} pairs and issues them one at a time to the
// WiFi TX engine over start/bussy. Optional handshake timeout enabled by SEQ_TIMEOUT_EN.
module wifi_cmd_sequencer
  import wifi_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH_LOG2  = 3,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [BYTE_W-1:0]   cmd_in,
  input  logic [BYTE_W-1:0]   dat_in,
  input  logic                flush,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                ovf,
  output logic                seq_busy,
  output logic [BYTE_W-1:0]   eng_comando,
  output logic [BYTE_W-1:0]   eng_dato,
  output logic                eng_start,
  input  logic                eng_bussy,
  output logic                err_to
);

  seq_state_e          state_r;
  seq_state_e          state_s;
  logic                pop_s;
  logic                eng_start_r;
  logic                eng_start_s;
  logic                ovf_r;
  logic [BYTE_W-1:0]   eng_comando_r;
  logic [BYTE_W-1:0]   eng_dato_r;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [DEPTH_LOG2:0] fifo_count_s;
  logic [ENTRY_W-1:0]  fifo_dout_s;
  logic                timeout_hit_s;

  cmd_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_s),
    .flush (flush),
    .din   (pack_entry(cmd_in, dat_in)),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s),
    .dout  (fifo_dout_s)
  );

  assign full        = fifo_full_s;
  assign count       = fifo_count_s;
  assign ovf         = ovf_r;
  assign seq_busy    = ~fifo_empty_s | (state_r != S_IDLE);
  assign eng_comando = eng_comando_r;
  assign eng_dato    = eng_dato_r;
  assign eng_start   = eng_start_r;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST_C = 32'(TIMEOUT_CYC - 1);

  logic [31:0] phase_cnt_r;
  logic        err_to_r;

  assign timeout_hit_s = (phase_cnt_r == TIMEOUT_LAST_C);
  assign err_to        = err_to_r;

  // Phase counter restarts on every state change, so it measures time spent in the current phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt_r <= 32'd0;
    end else if (state_s != state_r) begin
      phase_cnt_r <= 32'd0;
    end else begin
      phase_cnt_r <= phase_cnt_r + 32'd1;
    end
  end

  // Sticky timeout flag, raised only when the handshake phase is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_to_r <= 1'b0;
    end else if (flush) begin
      err_to_r <= 1'b0;
    end else if (timeout_hit_s &&
                 (((state_r == S_START) && !eng_bussy) ||
                  ((state_r == S_WAIT_DONE) && eng_bussy))) begin
      err_to_r <= 1'b1;
    end else begin
      err_to_r <= err_to_r;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign err_to        = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, pop request and next eng_start level.
  always_comb begin
    state_s     = state_r;
    pop_s       = 1'b0;
    eng_start_s = eng_start_r;
    case (state_r)
      S_IDLE: begin
        eng_start_s = 1'b0;
        // A flush in the same cycle must not let the head escape into flight.
        if (!fifo_empty_s && !eng_bussy && !flush) begin
          pop_s   = 1'b1;
          state_s = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        state_s     = S_START;
        eng_start_s = 1'b1;
      end
      S_START: begin
        if (eng_bussy) begin
          state_s     = S_WAIT_DONE;
          eng_start_s = 1'b0;
        end else if (timeout_hit_s) begin
          state_s     = S_IDLE;
          eng_start_s = 1'b0;
        end else begin
          state_s     = S_START;
          eng_start_s = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        eng_start_s = 1'b0;
        if (!eng_bussy || timeout_hit_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT_DONE;
        end
      end
      default: begin
        state_s     = S_IDLE;
        eng_start_s = 1'b0;
      end
    endcase
  end

  // Registered engine interface and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_start_r   <= 1'b0;
      eng_comando_r <= {BYTE_W{1'b0}};
      eng_dato_r    <= {BYTE_W{1'b0}};
      ovf_r         <= 1'b0;
    end else begin
      eng_start_r <= eng_start_s;
      if (pop_s) begin
        eng_comando_r <= fifo_dout_s[ENTRY_W-1:BYTE_W];
        eng_dato_r    <= fifo_dout_s[BYTE_W-1:0];
      end
      if (flush) begin
        ovf_r <= 1'b0;
      end else if (push && fifo_full_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wifi_cmd_sequencer.sv
// Self-checking bench for wifi_cmd_sequencer: directed sequences, a vector table for
// queue boundaries, and random traffic checked against an in-order issue scoreboard.
`timescale 1ns/1ps
module tb_wifi_cmd_sequencer;

  localparam int DL2    = 3;
  localparam int TO_CYC = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push = 1'b0;
  logic         flush = 1'b0;
  logic         eng_bussy = 1'b0;
  logic [7:0]   cmd_in = 8'h00;
  logic [7:0]   dat_in = 8'h00;
  logic         full, ovf, seq_busy, eng_start, err_to;
  logic [DL2:0] count;
  logic [7:0]   eng_comando, eng_dato;

  wifi_cmd_sequencer #(.DEPTH_LOG2(DL2), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .push(push), .cmd_in(cmd_in), .dat_in(dat_in), .flush(flush),
    .full(full), .count(count), .ovf(ovf), .seq_busy(seq_busy),
    .eng_comando(eng_comando), .eng_dato(eng_dato), .eng_start(eng_start),
    .eng_bussy(eng_bussy), .err_to(err_to)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;          // 0: engine responds, 1: engine held busy, 2: engine never responds
  int busy_len = 10;
  int busy_left = 0;
  bit start_seen = 1'b0;
  logic prev_start = 1'b0;
  logic prev_bussy = 1'b0;
  logic [15:0] issued_q[$];
  int          issue_cyc_q[$];
  int          fall_cyc_q[$];
  logic [15:0] exp_q[$];

  typedef struct {
    logic       push;
    logic       flush;
    logic [7:0] cmd;
    logic [7:0] dat;
    int         exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample after the edge, log issues, then advance the engine model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (eng_start && !prev_start) begin
      issued_q.push_back({eng_comando, eng_dato});
      issue_cyc_q.push_back(cyc);
    end
    prev_start = eng_start;
    case (mode)
      1: eng_bussy = 1'b1;
      2: eng_bussy = 1'b0;
      default: begin
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) eng_bussy = 1'b0;
        end else if (start_seen) begin
          eng_bussy  = 1'b1;
          busy_left  = busy_len;
          start_seen = 1'b0;
        end else if (eng_start && !eng_bussy) begin
          start_seen = 1'b1;
        end
      end
    endcase
    if (prev_bussy && !eng_bussy) fall_cyc_q.push_back(cyc);
    prev_bussy = eng_bussy;
  endtask

  task automatic set_mode(input int m);
    mode = m;
    if (m == 0) begin
      eng_bussy  = 1'b0;
      busy_left  = 0;
      start_seen = 1'b0;
    end
  endtask

  task automatic clear_logs();
    issued_q.delete();
    issue_cyc_q.delete();
    fall_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (seq_busy && n < limit) begin
      step();
      n++;
    end
    chk(name, seq_busy, 1'b0);
  endtask

  task automatic push_one(input logic [7:0] c, input logic [7:0] d);
    push = 1'b1; cmd_in = c; dat_in = d;
    step();
    push = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---------------- reset state
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_cmd", eng_comando, 0);
    chk("rst_dat", eng_dato, 0);
    chk("rst_err", err_to, 0);

    // ---------------- single pair, latency push+3
    clear_logs();
    set_mode(0);
    busy_len = 10;
    n = cyc;
    push_one(8'h41, 8'h55);
    chk("t1_start_n1", eng_start, 0);
    step();
    chk("t1_start_n2", eng_start, 0);
    step();
    chk("t1_start_n3", eng_start, 1);
    chk("t1_cmd", eng_comando, 8'h41);
    chk("t1_dat", eng_dato, 8'h55);
    step();
    chk("t1_start_held", eng_start, 1);
    step();
    chk("t1_start_dropped", eng_start, 0);
    wait_idle(40, "t1_idle_timeout");
    chk("t1_issue_cyc", issue_cyc_q.size() > 0 ? issue_cyc_q[0] - n : -1, 3);
    chk("t1_cmd_stable", eng_comando, 8'h41);

    // ---------------- four back-to-back pairs
    clear_logs();
    busy_len = 3;
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; cmd_in = 8'h10 + 8'(i); dat_in = 8'hA0 + 8'(i);
      step();
    end
    push = 1'b0;
    chk("t2_count_after_push", count, 3);
    wait_idle(100, "t2_idle_timeout");
    chk("t2_count_end", count, 0);
    chk("t2_issue_n", issued_q.size(), 4);
    for (int i = 0; i < 4 && i < issued_q.size(); i++)
      chk($sformatf("t2_order_%0d", i), issued_q[i], {8'h10 + 8'(i), 8'hA0 + 8'(i)});
    if (issue_cyc_q.size() == 4 && fall_cyc_q.size() >= 3) begin
      chk("t2_first_lat", issue_cyc_q[0] - n, 3);
      for (int i = 1; i < 4; i++)
        chk($sformatf("t2_b2b_%0d", i), issue_cyc_q[i] - fall_cyc_q[i-1], 3);
    end else begin
      chk("t2_log_sizes", fall_cyc_q.size(), 4);
    end

    // ---------------- queue boundaries with engine held busy (vector table)
    for (int i = 0; i < 10; i++)
      vecs[i] = '{1'b1, 1'b0, 8'h60 + 8'(i), 8'h70 + 8'(i), (i < 8) ? i + 1 : 8, i >= 7, i >= 8};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8'hEE, 8'hEE, 0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h33, 8'h44, 1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b0};
    clear_logs();
    set_mode(1);
    step();
    for (int i = 0; i < 15; i++) begin
      push = vecs[i].push; flush = vecs[i].flush;
      cmd_in = vecs[i].cmd; dat_in = vecs[i].dat;
      step();
      push = 1'b0; flush = 1'b0;
      chk($sformatf("tbl_count_%0d", i), count, vecs[i].exp_count);
      chk($sformatf("tbl_full_%0d", i), full, vecs[i].exp_full);
      chk($sformatf("tbl_ovf_%0d", i), ovf, vecs[i].exp_ovf);
      chk($sformatf("tbl_busy_%0d", i), seq_busy, vecs[i].exp_count != 0);
      chk($sformatf("tbl_start_%0d", i), eng_start, 0);
    end
    set_mode(0);
    step();

    // ---------------- flush with entry in flight and full queue
    clear_logs();
    busy_len = 25;
    push_one(8'hC0, 8'h01);
    step();
    step();
    chk("t4_inflight_start", eng_start, 1);
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; cmd_in = 8'hD0 + 8'(i); dat_in = 8'(i);
      step();
    end
    push = 1'b0;
    chk("t4_count_full", count, 8);
    chk("t4_ovf_set", ovf, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_count_flushed", count, 0);
    chk("t4_full_flushed", full, 0);
    chk("t4_ovf_cleared", ovf, 0);
    chk("t4_err_cleared", err_to, 0);
    chk("t4_still_busy", seq_busy, 1);
    wait_idle(60, "t4_idle_timeout");
    repeat (20) step();
    chk("t4_issue_n", issued_q.size(), 1);
    chk("t4_inflight_entry", issued_q.size() > 0 ? issued_q[0] : 16'hFFFF, 16'hC001);

    // ---------------- engine never acknowledges
    clear_logs();
    set_mode(2);
    n = cyc;
    push_one(8'hE1, 8'h11);
    push_one(8'hE2, 8'h22);
`ifdef SEQ_TIMEOUT_EN
    while (cyc < n + 3 + TO_CYC - 1) step();
    chk("t5_start_before_to", eng_start, 1);
    step();
    chk("t5_start_after_to", eng_start, 0);
    chk("t5_err_set", err_to, 1);
    repeat (3) step();
    chk("t5_next_issue_cyc", issue_cyc_q.size() > 1 ? issue_cyc_q[1] - n : -1, 3 + TO_CYC + 2);
`else
    while (cyc < n + 3 + TO_CYC + 5) step();
    chk("t5_start_held", eng_start, 1);
    chk("t5_err_zero", err_to, 0);
    chk("t5_count_waiting", count, 1);
`endif
    set_mode(0);
    busy_len = 2;
    wait_idle(200, "t5_idle_timeout");
    chk("t5_issue_n", issued_q.size(), 2);
    chk("t5_first", issued_q.size() > 0 ? issued_q[0] : 16'hFFFF, 16'hE111);
    chk("t5_second", issued_q.size() > 1 ? issued_q[1] : 16'hFFFF, 16'hE222);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_err_flushed", err_to, 0);

    // ---------------- reset in S_WAIT_DONE with three queued
    clear_logs();
    busy_len = 20;
    for (int i = 0; i < 4; i++) push_one(8'hB0 + 8'(i), 8'h0F);
    repeat (4) step();
    chk("t6_count_pre", count, 3);
    chk("t6_start_pre", eng_start, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_full", full, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_busy", seq_busy, 0);
    chk("t6_start", eng_start, 0);
    chk("t6_cmd", eng_comando, 0);
    chk("t6_dat", eng_dato, 0);
    chk("t6_err", err_to, 0);
    set_mode(0);
    repeat (10) step();
    chk("t6_no_reissue", issued_q.size(), 1);

    // ---------------- random traffic vs in-order scoreboard
    clear_logs();
    for (int k = 0; k < 400; k++) begin
      busy_len = int'($urandom_range(1, 6));
      push = ($urandom_range(0, 99) < 35) && !full;
      cmd_in = 8'($urandom);
      dat_in = 8'($urandom);
      if (push) exp_q.push_back({cmd_in, dat_in});
      step();
    end
    push = 1'b0;
    wait_idle(600, "rnd_idle_timeout");
    chk("rnd_issue_n", issued_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++)
      chk($sformatf("rnd_entry_%0d", i), issued_q[i], exp_q[i]);
    chk("rnd_ovf", ovf, 0);
    chk("rnd_count_end", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
